// File: rtl/computation_controller.sv
// Initiator side of the computation handshake: load, run one engine, capture the 2x2 result
// and stream it out as four bytes on a valid/ready port. All outputs are registered.
module computation_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       active_send,
  output logic       active_single,
  output logic       active_sa3,
  output logic       active_sa2,
  input  logic       done_send,
  input  logic       done_single,
  input  logic       done_sa3,
  input  logic       done_sa2,
  input  logic [7:0] c11,
  input  logic [7:0] c12,
  input  logic [7:0] c21,
  input  logic [7:0] c22,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic [1:0]    MODE_SINGLE = 2'd0;
  localparam logic [1:0]    MODE_SA3    = 2'd1;
  localparam logic [1:0]    MODE_SA2    = 2'd2;
  localparam logic [1:0]    MODE_BAD    = 2'd3;
  localparam logic [TW-1:0] CNT_LAST    = TW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] cap_q, cap_d;

  logic       busy_q, busy_d;
  logic       act_send_q, act_send_d;
  logic       act_single_q, act_single_d;
  logic       act_sa3_q, act_sa3_d;
  logic       act_sa2_q, act_sa2_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       err_q, err_d;

  logic done_sel;

  always_comb begin
    done_sel = 1'b0;
    case (mode_q)
      MODE_SINGLE: done_sel = done_single;
      MODE_SA3:    done_sel = done_sa3;
      MODE_SA2:    done_sel = done_sa2;
      default:     done_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode != MODE_BAD) begin
            mode_d  = mode;
            state_d = S_SEND;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (done_send) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_COMPUTE: begin
        if (done_sel) begin
          cap_d      = {c22, c21, c12, c11};
          state_d    = S_DRAIN;
          idx_d      = 2'd0;
          out_data_d = c11;
          out_last_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        // Advance only on an accepted handshake; data and last hold while stalled.
        if (out_valid_q && out_ready) begin
          if (idx_q == 2'd3) begin
            state_d    = S_IDLE;
            out_last_d = 1'b0;
          end else begin
            idx_d      = idx_q + 2'd1;
            out_data_d = cap_q[idx_q + 2'd1];
            out_last_d = (idx_q == 2'd2);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they are mutually exclusive and registered.
    busy_d       = (state_d != S_IDLE);
    act_send_d   = (state_d == S_SEND);
    act_single_d = (state_d == S_COMPUTE) && (mode_d == MODE_SINGLE);
    act_sa3_d    = (state_d == S_COMPUTE) && (mode_d == MODE_SA3);
    act_sa2_d    = (state_d == S_COMPUTE) && (mode_d == MODE_SA2);
    out_valid_d  = (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      cap_q        <= '0;
      busy_q       <= 1'b0;
      act_send_q   <= 1'b0;
      act_single_q <= 1'b0;
      act_sa3_q    <= 1'b0;
      act_sa2_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      busy_q       <= busy_d;
      act_send_q   <= act_send_d;
      act_single_q <= act_single_d;
      act_sa3_q    <= act_sa3_d;
      act_sa2_q    <= act_sa2_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
    end
  end

  assign busy          = busy_q;
  assign active_send   = act_send_q;
  assign active_single = act_single_q;
  assign active_sa3    = act_sa3_q;
  assign active_sa2    = act_sa2_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign err           = err_q;

endmodule
